// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic readout collector.
package systolic_pkg;

    // Collector sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Default geometry of the 8x8 accumulator array readout.
    localparam int DEF_ROWS  = 8;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LAT   = 1;

    // Width of an index able to hold 0..n-1. Never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_buffer.sv
// ROWS x WIDTH register file: one write port, one asynchronous read port.
module result_buffer
    import systolic_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [idx_w(ROWS)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [idx_w(ROWS)-1:0]   raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [ROWS];

    // Store one captured result byte per write strobe.
    // NOTE: storage has no reset; every entry is rewritten during CAPTURE
    // before it can be read, and the top masks rd_data outside DRAIN.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read the entry currently selected by the drain index.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/systolic_readout_collector.sv
// Drives the array readout line, captures ROWS shifted-out result bytes
// and serves them to a consumer over a valid/ready stream.
module systolic_readout_collector
    import systolic_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     readout,
    input  logic [WIDTH-1:0]         array_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [idx_w(ROWS)-1:0]   rd_index,
    output logic                     busy,
    output logic                     done,
    output logic                     start_err
);

    localparam int IW = idx_w(ROWS);
    localparam int WW = idx_w(LAT + 1);

    localparam logic [WW-1:0] WAIT_LAST = WW'(LAT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(ROWS - 1);

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [IW-1:0]   cap_q, cap_d;
    logic [IW-1:0]   rdi_q, rdi_d;
    logic            readout_q, readout_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            buf_we;
    logic [WIDTH-1:0] buf_rdata;

    result_buffer #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (cap_q),
        .wdata_i (array_data),
        .raddr_i (rdi_q),
        .rdata_o (buf_rdata)
    );

    // Next-state logic: sequencing, counters, readout line and status flags.
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cap_d     = cap_q;
        rdi_d     = rdi_q;
        readout_d = readout_q;
        done_d    = 1'b0;
        err_d     = err_q;
        buf_we    = 1'b0;

        // A request that arrives while a sequence is running is only flagged.
        if (start && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    readout_d = 1'b1;
                    wait_d    = '0;
                    cap_d     = '0;
                    err_d     = 1'b0;
                end
            end
            ARM: begin
                // Cover the array's pipeline delay before the first byte lands.
                if (wait_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CAPTURE: begin
                buf_we = 1'b1;
                if (cap_q == IDX_LAST) begin
                    state_d   = DRAIN;
                    readout_d = 1'b0;
                    rdi_d     = '0;
                end else begin
                    cap_d = cap_q + 1'b1;
                end
            end
            DRAIN: begin
                if (rd_ready) begin
                    if (rdi_q == IDX_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        rdi_d   = '0;
                    end else begin
                        rdi_d = rdi_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                readout_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops the readout line without waiting for a clock.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            cap_q     <= '0;
            rdi_q     <= '0;
            readout_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cap_q     <= cap_d;
            rdi_q     <= rdi_d;
            readout_q <= readout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Output decode; the buffer is only visible while draining.
    always_comb begin
        rd_valid  = (state_q == DRAIN);
        rd_data   = rd_valid ? buf_rdata : '0;
        rd_index  = rdi_q;
        busy      = (state_q != IDLE);
        readout   = readout_q;
        done      = done_q;
        start_err = err_q;
    end

endmodule
